seq_sub_32: RTL and testbench

- Multi-cycle 32-bit subtractor; the inverse operation to the team's 32-bit parallel prefix adder.
- Computes D = A - B - Bin. It works CHUNK bits per cycle and carries the borrow between cycles in a register, so each cycle's logic stays small.
- Sits in the datapath beside the adder and uses a valid/ready handshake on both input and output.

---
 rtl/seq_sub_32.sv | 135 +++++++++++++
 tb/tb_seq_sub_32.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_sub_32.sv
// Multi-cycle subtractor: D = A - B - Bin, CHUNK bits per cycle with a registered borrow.
// Valid/ready on both sides; one operation in flight at a time.
module seq_sub_32 #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
  // in_ready is high only in IDLE and out_valid only in DONE, so they are never both 1.

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_diff;
  logic [WIDTH-1:0] w_d_next;
  logic             w_last;

  // Extra top bit of w_diff goes to 1 exactly when the chunk result is negative.
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(r_cnt) == k) begin
        w_a_chunk = r_a[k*CHUNK +: CHUNK];
        w_b_chunk = r_b[k*CHUNK +: CHUNK];
      end
    end
    w_diff   = {1'b0, w_a_chunk} - {1'b0, w_b_chunk} - {{CHUNK{1'b0}}, r_borrow};
    w_d_next = r_d;
    for (int k = 0; k < N; k++) begin
      if (int'(r_cnt) == k) begin
        w_d_next[k*CHUNK +: CHUNK] = w_diff[CHUNK-1:0];
      end
    end
    w_last = (int'(r_cnt) == N - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_borrow    <= 1'b0;
      r_cnt       <= '0;
      r_d         <= '0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_borrow   <= bin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end
        end
        CALC: begin
          r_d      <= w_d_next;
          r_borrow <= w_diff[CHUNK];
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            // Flags use the completed result, which is only whole on the last chunk.
            r_bout      <= w_diff[CHUNK];
            r_ovf       <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_d_next[WIDTH-1] != r_a[WIDTH-1]);
            r_zero      <= (w_d_next == '0);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign d         = r_d;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_sub_32.sv
// Directed bench for seq_sub_32 at default parameters (4 chunks of 8 bits).
module tb_seq_sub_32;

  localparam int WIDTH = 32;
  localparam int N     = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
  logic             zero;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;

  seq_sub_32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, bout, ovf, zero} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: got rdy=%0b vld=%0b bout=%0b ovf=%0b zero=%0b, want 1 0 0 0 0",
               in_ready, out_valid, bout, ovf, zero);
    end
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_d: got %h, want 00000000", d);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d, want 0", dbg_state);
    end
  endtask

  // Issue one operation with out_ready=1 and check latency, result and the return to idle.
  task automatic test_op(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic tbin, input logic [31:0] ed, input logic eb,
                         input logic eo, input logic ez);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    a = ta;
    b = tb_;
    bin = tbin;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_before: got %0b, want 1", name, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    checks++;
    if (lat !== N) begin
      errors++;
      $display("FAIL %s_latency: got %0d, want %0d", name, lat, N);
    end
    checks++;
    if (d !== ed) begin
      errors++;
      $display("FAIL %s_d: got %h, want %h", name, d, ed);
    end
    checks++;
    if ({bout, ovf, zero, in_ready} !== {eb, eo, ez, 1'b0}) begin
      errors++;
      $display("FAIL %s_flags: got bout=%0b ovf=%0b zero=%0b rdy=%0b, want %0b %0b %0b 0",
               name, bout, ovf, zero, in_ready, eb, eo, ez);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01 || d !== ed) begin
      errors++;
      $display("FAIL %s_after: got vld=%0b rdy=%0b d=%h, want 0 1 %h", name, out_valid, in_ready, d, ed);
    end
  endtask

  task automatic test_back_pressure();
    int lat;
    @(negedge clk);
    out_ready = 1'b0;
    a = 32'h0000_0010;
    b = 32'h0000_0003;
    bin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    checks++;
    if (lat !== N) begin
      errors++;
      $display("FAIL bp_latency: got %0d, want %0d", lat, N);
    end
    a = 32'h0000_0055;
    b = 32'h0000_0011;
    bin = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b10 || d !== 32'h0000_000D) begin
        errors++;
        $display("FAIL bp_hold_%0d: got vld=%0b rdy=%0b d=%h, want 1 0 0000000d", i, out_valid, in_ready, d);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01 || dbg_state !== 2'd0 || d !== 32'h0000_000D) begin
      errors++;
      $display("FAIL bp_release: got vld=%0b rdy=%0b st=%0d d=%h, want 0 1 0 0000000d",
               out_valid, in_ready, dbg_state, d);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    out_ready = 1'b1;
    a = 32'hFFFF_FFFF;
    b = 32'h0000_0001;
    bin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10 || d !== 32'h0) begin
      errors++;
      $display("FAIL midrst_state: got rdy=%0b vld=%0b d=%h, want 1 0 00000000", in_ready, out_valid, d);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_no_result_%0d: got vld=%0b, want 0", i, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_op("basic",   32'h0000_1234, 32'h0000_0234, 1'b0, 32'h0000_1000, 1'b0, 1'b0, 1'b0);
    test_op("zero_m1", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    test_op("eq_bin",  32'h0000_0005, 32'h0000_0005, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    test_op("ovf_neg", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    test_op("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    test_op("zero",    32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    test_op("mixed",   32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 32'h0325_4768, 1'b0, 1'b0, 1'b0);
    test_back_pressure();
    test_op("after_bp", 32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
    test_reset_mid_op();
    test_op("after_rst", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
